// File: rtl/phase_avg_decimator.sv
// phase_avg_decimator
// Averages non-overlapping windows of 2^LOG2_N signed phase samples and queues
// each window average in a first-word-fall-through FIFO read over valid/ready.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   run            1 = accumulate windows, 0 = idle and drop the partial window
//   phase_in       signed 16-bit phase sample
//   phase_in_en    one-cycle strobe qualifying phase_in
//   m_data         head-of-FIFO window average
//   m_valid        FIFO non-empty
//   m_ready        downstream accepts m_data
//   fifo_level     FIFO occupancy
//   overflow       sticky: a result was dropped because the FIFO was full
//   busy           accumulating (state ACCUM)
module phase_avg_decimator #(
    parameter int unsigned LOG2_N     = 6,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned AW         = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic [15:0]   phase_in,
    input  logic          phase_in_en,
    output logic [15:0]   m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [AW:0]   fifo_level,
    output logic          overflow,
    output logic          busy
);

    localparam int unsigned ACCW = 16 + LOG2_N;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    state_t                   r_state;
    logic                     r_busy;
    logic                     r_run_d;
    logic signed [ACCW-1:0]   r_acc;
    logic [LOG2_N-1:0]        r_cnt;

    logic                     r_push_vld;
    logic [15:0]              r_push_data;

    logic [15:0]              r_mem [FIFO_DEPTH];
    logic [AW-1:0]            r_wr_ptr;
    logic [AW-1:0]            r_rd_ptr;
    logic [AW:0]              r_level;
    logic                     r_valid;
    logic                     r_overflow;

    logic signed [ACCW-1:0]   w_ext;
    logic signed [ACCW-1:0]   w_sum;
    logic [15:0]              w_avg;
    logic                     w_complete;
    logic                     w_pop;
    logic                     w_full;
    logic                     w_wr;
    logic                     w_drop;
    logic                     w_run_rise;
    logic [AW:0]              w_level_nxt;

    // Sign-extended running sum including the current sample
    assign w_ext = ACCW'($signed(phase_in));
    assign w_sum = r_acc + w_ext;
    // Taking bits above LOG2_N of a two's-complement sum is floor division
    assign w_avg = w_sum[LOG2_N +: 16];

    assign w_complete = (r_state == S_ACCUM) && run && phase_in_en && (&r_cnt);

    // Window FSM, accumulator and sample counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state <= S_ACCUM;
                        r_busy  <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (!run) begin
                        // Partial window is discarded
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end else if (phase_in_en) begin
                        if (&r_cnt) begin
                            r_acc <= '0;
                            r_cnt <= '0;
                        end else begin
                            r_acc <= w_sum;
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Push stage: one-cycle register between window completion and FIFO write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_push_vld  <= 1'b0;
            r_push_data <= '0;
        end else begin
            r_push_vld <= w_complete;
            if (w_complete) begin
                r_push_data <= w_avg;
            end
        end
    end

    // FIFO control; a full FIFO still accepts a write when the head pops
    assign w_pop       = r_valid && m_ready;
    assign w_full      = (r_level == (AW+1)'(FIFO_DEPTH));
    assign w_wr        = r_push_vld && (!w_full || w_pop);
    assign w_drop      = r_push_vld && w_full && !w_pop;
    assign w_run_rise  = run && !r_run_d;
    assign w_level_nxt = r_level + (AW+1)'(w_wr) - (AW+1)'(w_pop);

    // FIFO storage, pointers, level and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_run_d    <= 1'b0;
        end else begin
            r_run_d <= run;
            if (w_wr) begin
                r_mem[r_wr_ptr] <= r_push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= w_level_nxt;
            r_valid <= (w_level_nxt != '0);
            if (w_run_rise) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign m_data     = r_mem[r_rd_ptr];
    assign m_valid    = r_valid;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;
    assign busy       = r_busy;

endmodule

// File: tb/tb_phase_avg_decimator.sv
module tb_phase_avg_decimator;

    localparam int L2    = 2;
    localparam int NW    = 1 << L2;
    localparam int DEPTH = 4;
    localparam int AWB   = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic [15:0]   phase_in = '0;
    logic          phase_in_en = 1'b0;
    logic [15:0]   m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [AWB:0]  fifo_level;
    logic          overflow;
    logic          busy;

    int n_chk  = 0;
    int n_pass = 0;

    phase_avg_decimator #(.LOG2_N(L2), .FIFO_DEPTH(DEPTH), .AW(AWB)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .phase_in(phase_in),
        .phase_in_en(phase_in_en), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .fifo_level(fifo_level), .overflow(overflow),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit          md_busy;
    int          md_win[$];
    bit          md_pend_v;
    logic [15:0] md_pend;
    logic [15:0] md_fifo[$];
    bit          md_ovf;
    bit          md_run_prev;
    logic [15:0] pop_log[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_busy = 0; md_win.delete(); md_pend_v = 0; md_pend = '0;
            md_fifo.delete(); md_ovf = 0; md_run_prev = 0;
        end else begin
            bit pop;
            bit drop;
            int sz0;
            sz0  = md_fifo.size();
            pop  = (sz0 != 0) && m_ready;
            drop = 0;
            if (pop) pop_log.push_back(md_fifo.pop_front());
            if (md_pend_v) begin
                if (sz0 == DEPTH && !pop) drop = 1;
                else md_fifo.push_back(md_pend);
            end
            if (run && !md_run_prev) md_ovf = 0;
            else if (drop) md_ovf = 1;
            md_pend_v = 0;
            if (!md_busy) begin
                if (run) md_busy = 1;
            end else if (!run) begin
                md_busy = 0;
                md_win.delete();
            end else if (phase_in_en) begin
                md_win.push_back(int'($signed(phase_in)));
                if (md_win.size() == NW) begin
                    int s;
                    int q;
                    s = 0;
                    foreach (md_win[i]) s += md_win[i];
                    q = s / NW;
                    if ((s % NW) != 0 && s < 0) q = q - 1;
                    md_pend_v = 1;
                    md_pend   = 16'(q);
                    md_win.delete();
                end
            end
            md_run_prev = run;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", int'(busy), int'(md_busy));
            chk("m_valid", int'(m_valid), int'(md_fifo.size() != 0));
            chk("fifo_level", int'(fifo_level), md_fifo.size());
            chk("overflow", int'(overflow), int'(md_ovf));
            if (md_fifo.size() != 0) chk("m_data", int'(m_data), int'(md_fifo[0]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic [15:0] v);
        phase_in    = v;
        phase_in_en = 1'b1;
        @(negedge clk);
        phase_in_en = 1'b0;
    endtask

    task automatic win(input logic [15:0] v);
        repeat (NW) strobe(v);
    endtask

    task automatic run_toggle();
        run = 1'b0; tick();
        run = 1'b1; tick();
    endtask

    initial begin
        tick(2);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_busy", int'(busy), 0);
        #2 rst_n = 1'b1;
        tick();

        // 1: constant input, latency of the first result
        m_ready = 1'b1;
        run = 1'b1; tick();
        chk("t1_busy", int'(busy), 1);
        repeat (4) strobe(16'h0100);
        chk("t1_valid_push_stage", int'(m_valid), 0);
        strobe(16'h0100);
        chk("t1_valid_first", int'(m_valid), 1);
        chk("t1_data_first", int'(m_data), 16'h0100);
        repeat (3) strobe(16'h0100);
        tick(3);
        chk("t1_count", pop_log.size(), 2);
        chk("t1_r0", int'(pop_log[0]), 16'h0100);
        chk("t1_r1", int'(pop_log[1]), 16'h0100);
        chk("t1_busy_end", int'(busy), 1);
        pop_log.delete();

        // 2: sign and floor
        strobe(16'hFFFF); strobe(16'hFFFF); strobe(16'hFFFF); strobe(16'h0000);
        win(16'h8000);
        tick(3);
        chk("t2_count", pop_log.size(), 2);
        chk("t2_floor", int'(pop_log[0]), 16'hFFFF);
        chk("t2_min", int'(pop_log[1]), 16'h8000);
        pop_log.delete();

        // 3: back-pressure and full
        m_ready = 1'b0;
        for (int k = 1; k <= 6; k++) win(16'(k));
        tick(2);
        chk("t3_level", int'(fifo_level), 4);
        chk("t3_overflow", int'(overflow), 1);
        m_ready = 1'b1;
        tick(8);
        chk("t3_count", pop_log.size(), 4);
        for (int k = 0; k < 4; k++) chk("t3_order", int'(pop_log[k]), k + 1);
        chk("t3_empty", int'(m_valid), 0);
        pop_log.delete();

        // 4: write into a full FIFO with a simultaneous pop
        run_toggle();
        chk("t4_ovf_cleared", int'(overflow), 0);
        m_ready = 1'b0;
        for (int k = 10; k <= 13; k++) win(16'(k));
        tick(2);
        chk("t4_full", int'(fifo_level), 4);
        win(16'd14);
        m_ready = 1'b1; tick();
        m_ready = 1'b0;
        chk("t4_level", int'(fifo_level), 4);
        chk("t4_no_ovf", int'(overflow), 0);
        m_ready = 1'b1;
        tick(8);
        chk("t4_count", pop_log.size(), 5);
        for (int k = 0; k < 5; k++) chk("t4_order", int'(pop_log[k]), 10 + k);
        pop_log.delete();

        // 5: run drop mid-window; overflow cleared by the run edge
        m_ready = 1'b0;
        repeat (5) win(16'd1);
        tick(2);
        chk("t5_ovf_set", int'(overflow), 1);
        m_ready = 1'b1; tick(6);
        pop_log.delete();
        repeat (3) strobe(16'd9);
        run_toggle();
        chk("t5_ovf_cleared", int'(overflow), 0);
        win(16'd7);
        tick(3);
        chk("t5_count", pop_log.size(), 1);
        chk("t5_val", int'(pop_log[0]), 7);
        pop_log.delete();

        // 6: asynchronous reset with results queued mid-window
        m_ready = 1'b0;
        win(16'd3); win(16'd3);
        strobe(16'd3); strobe(16'd3);
        tick();
        chk("t6_level_pre", int'(fifo_level), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid", int'(m_valid), 0);
        chk("t6_level", int'(fifo_level), 0);
        chk("t6_overflow", int'(overflow), 0);
        chk("t6_busy", int'(busy), 0);
        tick();
        #2 rst_n = 1'b1;
        pop_log.delete();
        m_ready = 1'b1;
        tick();
        win(16'd5);
        tick(3);
        chk("t6_count", pop_log.size(), 1);
        chk("t6_val", int'(pop_log[0]), 5);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            run         = ($urandom_range(0, 79) != 0);
            phase_in_en = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       phase_in = 16'h8000;
                1:       phase_in = 16'h7FFF;
                default: phase_in = 16'($urandom);
            endcase
            m_ready = ($urandom_range(0, 2) == 0);
            tick();
        end
        phase_in_en = 1'b0;
        m_ready = 1'b1;
        tick(10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
